div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with these ports: clock input 1 (rising edge); reset input 1 (sync, active-high).
REQ-002 SHALL have these pipeline ports: req_valid_i input 1 (EX holds a divide op); op_i input 3 ([0]=word, [1]=unsigned, [2]=remainder); srcA_i input 64 (dividend); srcB_i input 64 (divisor); flush_i input 1 (kill the current op).
REQ-003 SHALL have these result ports: stall_o output 1 (freeze IF/ID/EX); result_valid_o output 1 (result_o valid this cycle); result_o output 64.
REQ-004 SHALL have these divider ports: div_start_o output 1; div_signed_o output 1; div_a_o output 64; div_b_o output 64; div_ready_i input 1; div_error_i input 1; div_q_i input 64; div_r_i input 64.

Function
REQ-005 SHALL extend word-op operands before use: sign-extend [31:0] if signed, zero-extend [31:0] if unsigned; 64-bit ops pass operands through unchanged.
REQ-006 SHALL use FSM states IDLE, RUN, DONE, DRAIN.
REQ-007 SHALL, in IDLE with req_valid_i=1 and a special case, register the special result and go to DONE; the divider is not started.
- Special case 1: extended divisor is 0.
- Special case 2: signed op with dividend at the most-negative value (2^63, or 2^31 for word ops) and divisor -1.
REQ-008 SHALL, in IDLE with req_valid_i=1 and no special case, register the extended operands and signedness, pulse div_start_o for exactly 1 cycle, and go to RUN.
REQ-009 SHALL produce these special results:
- Divide by zero: quotient = all ones, remainder = dividend.
- Overflow: quotient = dividend, remainder = 0.
REQ-010 SHALL hold div_a_o, div_b_o and div_signed_o stable from the start pulse until div_ready_i.
REQ-011 SHALL, in RUN on div_ready_i=1, capture div_q_i/div_r_i into the result register and go to DONE.
REQ-012 SHALL, in DONE, drive result_valid_o=1 and stall_o=0 for exactly 1 cycle, then return to IDLE.
REQ-013 SHALL select result_o as the quotient, or as the remainder when op_i[2]=1; word ops SHALL return bits [31:0] sign-extended to 64.
REQ-014 SHALL drive stall_o = req_valid_i & (state != DONE) & ~flush_i.
REQ-015 SHALL handle flush_i=1 by state:
- IDLE or DONE: go to IDLE and suppress result_valid_o.
- RUN: go to DRAIN.
REQ-016 SHALL, in DRAIN, ignore req_valid_i (stall_o=1 if requested) until div_ready_i, then go to IDLE, discarding q/r.
REQ-017 SHALL ignore div_error_i, which cannot assert because a zero divisor is never issued.
REQ-018 SHALL give this latency from acceptance to result_valid_o:
- Special case: 1 cycle.
- Normal op: divider latency + 1 cycle.
REQ-019 SHALL treat a simultaneous flush_i and div_ready_i in RUN as a flush (go to IDLE, discard the result).

Reset
REQ-020 SHALL, on reset, force the state to IDLE and clear the result register, the operand registers, and the cache valid bit.
REQ-021 SHALL drive these outputs to 0 during the reset cycle: div_start_o, result_valid_o, stall_o.
REQ-022 SHALL abandon any in-flight divide on reset, without entering DRAIN.

Configuration
REQ-023 SHALL implement a result cache when DIV_RESULT_CACHE_EN is defined:
- Each RUN capture stores the extended a, extended b, signedness, q and r.
- In IDLE, a non-special request whose extended operands and signedness equal the cached entry goes directly to DONE without a div_start_o pulse, so a DIV then REM of the same operands costs 1 cycle.
- The cache is not invalidated by flush_i.
REQ-024 SHALL, when DIV_RESULT_CACHE_EN is undefined, contain no cache storage; every non-special request starts the divider.

Verification
REQ-025 DIV srcA=100, srcB=7 -> one div_start_o pulse; result_o=14 with result_valid_o after ready; stall_o high until then.
REQ-026 DIVU and REMU with srcB=0, srcA=0x55 -> no start; results 0xFFFF_FFFF_FFFF_FFFF and 0x55 after 1 stall cycle.
REQ-027 DIVW srcA=0x8000_0000, srcB=0xFFFF_FFFF -> no start; result 0xFFFF_FFFF_8000_0000; REMW on the same operands -> 0.
REQ-028 DIV starts, then flush_i in the 3rd RUN cycle -> DRAIN; a new request stalls until div_ready_i; no result_valid_o for the flushed op.
REQ-029 With DIV_RESULT_CACHE_EN: DIV 100/7 then REM 100/7 -> the REM returns 2 after 1 cycle with no div_start_o; without the macro -> a second start.
REQ-030 Reset asserted in RUN -> next cycle IDLE; stall_o=0 and result_valid_o=0.

Source files
------------

// File: rtl/div_ctrl.sv
// Sequences a multi-cycle divider for the EX stage and handles special cases, flushes and result formatting.
// Optional result cache is enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_i,
    input  logic [2:0]  op_i,
    input  logic [63:0] srcA_i,
    input  logic [63:0] srcB_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [63:0] result_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [63:0] div_a_o,
    output logic [63:0] div_b_o,
    input  logic        div_ready_i,
    input  logic        div_error_i,
    input  logic [63:0] div_q_i,
    input  logic [63:0] div_r_i
);

    typedef enum logic [1:0] {IDLE, RUN, DONE, DRAIN} state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [63:0] r_a;
    logic [63:0] r_b;
    logic        r_signed;
    logic        r_rem;
    logic        r_word;
    logic [63:0] r_q;
    logic [63:0] r_r;

    logic        w_word;
    logic        w_signed;
    logic [63:0] w_extA;
    logic [63:0] w_extB;
    logic [63:0] w_minNeg;
    logic        w_divZero;
    logic        w_overflow;
    logic        w_special;
    logic [63:0] w_specialQ;
    logic [63:0] w_specialR;
    logic        w_cacheHit;
    logic [63:0] w_hitQ;
    logic [63:0] w_hitR;
    logic        w_accept;
    logic        w_capture;
    logic [63:0] w_sel;
    logic        w_unusedErr;

    // The divider never sees a zero divisor, so its error flag carries no information.
    assign w_unusedErr = div_error_i;

    assign w_word   = op_i[0];
    assign w_signed = ~op_i[1];
    assign w_extA   = !w_word ? srcA_i :
                      (w_signed ? {{32{srcA_i[31]}}, srcA_i[31:0]} : {32'd0, srcA_i[31:0]});
    assign w_extB   = !w_word ? srcB_i :
                      (w_signed ? {{32{srcB_i[31]}}, srcB_i[31:0]} : {32'd0, srcB_i[31:0]});

    assign w_minNeg   = w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_divZero  = (w_extB == 64'd0);
    assign w_overflow = w_signed & (w_extA == w_minNeg) & (w_extB == {64{1'b1}});
    assign w_special  = w_divZero | w_overflow;
    assign w_specialQ = w_divZero ? {64{1'b1}} : w_extA;
    assign w_specialR = w_divZero ? w_extA : 64'd0;

    assign w_accept  = (r_state == IDLE) & req_valid_i & ~flush_i;
    assign w_capture = (r_state == RUN) & div_ready_i & ~flush_i;

`ifdef DIV_RESULT_CACHE_EN
    logic        r_cacheValid;
    logic [63:0] r_cacheA;
    logic [63:0] r_cacheB;
    logic        r_cacheSigned;
    logic [63:0] r_cacheQ;
    logic [63:0] r_cacheR;

    assign w_cacheHit = r_cacheValid & (r_cacheA == w_extA) & (r_cacheB == w_extB)
                        & (r_cacheSigned == w_signed);
    assign w_hitQ     = r_cacheQ;
    assign w_hitR     = r_cacheR;

    // Flushes leave the entry intact: it still holds a correct q/r for its operands.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cacheValid  <= 1'b0;
            r_cacheA      <= 64'd0;
            r_cacheB      <= 64'd0;
            r_cacheSigned <= 1'b0;
            r_cacheQ      <= 64'd0;
            r_cacheR      <= 64'd0;
        end else if (w_capture) begin
            r_cacheValid  <= 1'b1;
            r_cacheA      <= r_a;
            r_cacheB      <= r_b;
            r_cacheSigned <= r_signed;
            r_cacheQ      <= div_q_i;
            r_cacheR      <= div_r_i;
        end
    end
`else
    assign w_cacheHit = 1'b0;
    assign w_hitQ     = 64'd0;
    assign w_hitR     = 64'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        div_start_o    = 1'b0;
        result_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_special || w_cacheHit) begin
                        w_nextState = DONE;
                    end else begin
                        w_nextState = RUN;
                        div_start_o = 1'b1;
                    end
                end
            end
            RUN: begin
                // A flush coinciding with ready has nothing left to drain.
                if (flush_i) begin
                    w_nextState = div_ready_i ? IDLE : DRAIN;
                end else if (div_ready_i) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState    = IDLE;
                result_valid_o = ~flush_i;
            end
            DRAIN: begin
                if (div_ready_i) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (reset) begin
            div_start_o    = 1'b0;
            result_valid_o = 1'b0;
        end
    end

    assign stall_o = req_valid_i & (r_state != DONE) & ~flush_i & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a      <= 64'd0;
            r_b      <= 64'd0;
            r_signed <= 1'b0;
            r_rem    <= 1'b0;
            r_word   <= 1'b0;
            r_q      <= 64'd0;
            r_r      <= 64'd0;
        end else begin
            if (w_accept) begin
                r_rem  <= op_i[2];
                r_word <= op_i[0];
                if (w_special || w_cacheHit) begin
                    r_q <= w_special ? w_specialQ : w_hitQ;
                    r_r <= w_special ? w_specialR : w_hitR;
                end else begin
                    r_a      <= w_extA;
                    r_b      <= w_extB;
                    r_signed <= w_signed;
                end
            end
            if (w_capture) begin
                r_q <= div_q_i;
                r_r <= div_r_i;
            end
        end
    end

    // Operands go out combinationally on the start cycle, then from the registers until ready.
    assign div_a_o      = (r_state == IDLE) ? w_extA : r_a;
    assign div_b_o      = (r_state == IDLE) ? w_extB : r_b;
    assign div_signed_o = (r_state == IDLE) ? w_signed : r_signed;

    assign w_sel    = r_rem ? r_r : r_q;
    assign result_o = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized ops against an arithmetic reference model.
// Cache expectations follow DIV_RESULT_CACHE_EN.
module tb_div_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [63:0] srcA_i = 64'd0;
    logic [63:0] srcB_i = 64'd0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        result_valid_o;
    logic [63:0] result_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic [63:0] div_a_o;
    logic [63:0] div_b_o;
    logic        div_ready_i = 1'b0;
    logic        div_error_i = 1'b0;
    logic [63:0] div_q_i = 64'd0;
    logic [63:0] div_r_i = 64'd0;

    int testsRun = 0;
    int testsFailed = 0;

    // Divider model state
    int          divLat = 3;
    bit          divBusy = 0;
    int          divCnt = 0;
    logic [63:0] divLatchA, divLatchB;
    logic        divLatchS;
    logic [63:0] divPendQ, divPendR;
    bit          readyDriven = 0;
    int          startCount = 0;

    // Reference cache: operands of the last divide that completed normally
    bit          cacheValid = 0;
    logic [63:0] cacheA, cacheB;
    logic        cacheS;

    div_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid_i    (req_valid_i),
        .op_i           (op_i),
        .srcA_i         (srcA_i),
        .srcB_i         (srcB_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .result_valid_o (result_valid_o),
        .result_o       (result_o),
        .div_start_o    (div_start_o),
        .div_signed_o   (div_signed_o),
        .div_a_o        (div_a_o),
        .div_b_o        (div_b_o),
        .div_ready_i    (div_ready_i),
        .div_error_i    (div_error_i),
        .div_q_i        (div_q_i),
        .div_r_i        (div_r_i)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
        end
    endtask

    function automatic void extendOps(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] ea, output logic [63:0] eb);
        int          sa32, sb32;
        int unsigned ua32, ub32;
        if (!op[0]) begin
            ea = a;
            eb = b;
        end else if (op[1]) begin
            ua32 = a[31:0];
            ub32 = b[31:0];
            ea = 64'(ua32);
            eb = 64'(ub32);
        end else begin
            sa32 = a[31:0];
            sb32 = b[31:0];
            ea = longint'(sa32);
            eb = longint'(sb32);
        end
    endfunction

    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                              output bit special);
        logic [63:0] ea, eb, q, r, res;
        longint      sa, sb;
        extendOps(op, a, b, ea, eb);
        sa = ea;
        sb = eb;
        special = 1;
        if (eb == 64'd0) begin
            q = {64{1'b1}};
            r = ea;
        end else if (!op[1] && sb == -1 &&
                     ((op[0] && sa == -64'sd2147483648) || (!op[0] && ea == 64'h8000_0000_0000_0000))) begin
            q = ea;
            r = 64'd0;
        end else begin
            special = 0;
            if (op[1]) begin
                q = ea / eb;
                r = ea % eb;
            end else begin
                q = 64'(sa / sb);
                r = 64'(sa % sb);
            end
        end
        res = op[2] ? r : q;
        if (op[0]) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    // One clock: drive inputs and the divider model just after the edge, then observe outputs.
    task automatic stepCycle(input logic rv, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                             input logic fl, input logic rst);
        longint sa, sb;
        @(posedge clock);
        #1;
        reset       = rst;
        req_valid_i = rv;
        op_i        = op;
        srcA_i      = a;
        srcB_i      = b;
        flush_i     = fl;
        div_ready_i = 1'b0;
        readyDriven = 0;
        if (rst) begin
            divBusy = 0;
        end else if (divBusy) begin
            divCnt--;
            if (divCnt == 0) begin
                div_ready_i = 1'b1;
                div_q_i     = divPendQ;
                div_r_i     = divPendR;
                divBusy     = 0;
                readyDriven = 1;
            end
        end
        #1;
        if (readyDriven) begin
            checkOutput("div_a_stable", div_a_o, divLatchA);
            checkOutput("div_b_stable", div_b_o, divLatchB);
            checkOutput("div_signed_stable", {63'd0, div_signed_o}, {63'd0, divLatchS});
        end
        if (div_start_o) begin
            startCount++;
            divBusy   = 1;
            divCnt    = divLat;
            divLatchA = div_a_o;
            divLatchB = div_b_o;
            divLatchS = div_signed_o;
            sa = div_a_o;
            sb = div_b_o;
            if (div_b_o == 64'd0) begin
                divPendQ = {64{1'b1}};
                divPendR = div_a_o;
            end else if (div_signed_o && sb == -1) begin
                divPendQ = 64'(-sa);
                divPendR = 64'd0;
            end else if (div_signed_o) begin
                divPendQ = 64'(sa / sb);
                divPendR = 64'(sa % sb);
            end else begin
                divPendQ = div_a_o / div_b_o;
                divPendR = div_a_o % div_b_o;
            end
        end
    endtask

    // Presents one op from an idle controller and checks result, latency, stall length and start count.
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] expRes, ea, eb;
        bit          special, hit, seen;
        int          expLat, stalls, k, startsBefore;
        expRes = refResult(op, a, b, special);
        extendOps(op, a, b, ea, eb);
        hit = 0;
`ifdef DIV_RESULT_CACHE_EN
        hit = !special && cacheValid && cacheA == ea && cacheB == eb && cacheS == !op[1];
`endif
        divLat       = $urandom_range(1, 6);
        expLat       = (special || hit) ? 1 : divLat + 1;
        startsBefore = startCount;
        stalls       = 0;
        seen         = 0;
        k            = 0;
        while (!seen && k < 40) begin
            stepCycle(1'b1, op, a, b, 1'b0, 1'b0);
            if (stall_o) stalls++;
            if (result_valid_o) begin
                seen = 1;
                checkOutput({name, "_result"}, result_o, expRes);
                checkOutput({name, "_latency"}, 64'(k), 64'(expLat));
            end else begin
                k++;
            end
        end
        if (!seen) checkOutput({name, "_timeout"}, 64'd0, 64'd1);
        checkOutput({name, "_stalls"}, 64'(stalls), 64'(expLat));
        checkOutput({name, "_starts"}, 64'(startCount - startsBefore), (special || hit) ? 64'd0 : 64'd1);
        if (!special && !hit) begin
            cacheValid = 1;
            cacheA     = ea;
            cacheB     = eb;
            cacheS     = !op[1];
        end
    endtask

    initial begin
        int          stallsSeen, validsSeen, startsBefore, n;
        logic [2:0]  rop;
        logic [63:0] ra, rb, lastA, lastB;
        int          kind;

        // Reset with a pending request: all handshake outputs must stay low.
        stepCycle(1'b1, 3'b000, 64'd100, 64'd7, 1'b0, 1'b1);
        checkOutput("reset_stall", {63'd0, stall_o}, 64'd0);
        checkOutput("reset_valid", {63'd0, result_valid_o}, 64'd0);
        checkOutput("reset_start", {63'd0, div_start_o}, 64'd0);
        stepCycle(1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 1'b0);
        cacheValid = 0;

        applyStimulus("div_100_7", 3'b000, 64'd100, 64'd7);
        applyStimulus("rem_100_7", 3'b100, 64'd100, 64'd7);
        applyStimulus("divu_zero", 3'b010, 64'h55, 64'd0);
        applyStimulus("remu_zero", 3'b110, 64'h55, 64'd0);
        applyStimulus("divw_ovf", 3'b001, 64'h8000_0000, 64'hFFFF_FFFF);
        applyStimulus("remw_ovf", 3'b101, 64'h8000_0000, 64'hFFFF_FFFF);
        applyStimulus("div_ovf64", 3'b000, 64'h8000_0000_0000_0000, {64{1'b1}});
        applyStimulus("divuw_neg", 3'b011, 64'hDEAD_BEEF_FFFF_FFF0, 64'h3);
        applyStimulus("remw_neg", 3'b101, 64'h1234_5678_FFFF_FF9C, 64'h7);

        // Flush in the third RUN cycle: a following request waits out the drain.
        divLat       = 8;
        startsBefore = startCount;
        validsSeen   = 0;
        stepCycle(1'b1, 3'b000, 64'd1000, 64'd3, 1'b0, 1'b0);
        checkOutput("drain_start", 64'(startCount - startsBefore), 64'd1);
        for (int c = 0; c < 2; c++) begin
            stepCycle(1'b1, 3'b000, 64'd1000, 64'd3, 1'b0, 1'b0);
            if (result_valid_o) validsSeen++;
        end
        stepCycle(1'b1, 3'b000, 64'd1000, 64'd3, 1'b1, 1'b0);
        checkOutput("drain_flush_stall", {63'd0, stall_o}, 64'd0);
        if (result_valid_o) validsSeen++;
        startsBefore = startCount;
        stallsSeen   = 0;
        n            = 0;
        do begin
            stepCycle(1'b1, 3'b000, 64'd123, 64'd0, 1'b0, 1'b0);
            if (stall_o) stallsSeen++;
            if (result_valid_o) validsSeen++;
            n++;
        end while (!readyDriven && n < 20);
        checkOutput("drain_stall_cycles", 64'(stallsSeen), 64'd5);
        checkOutput("drain_no_valid", 64'(validsSeen), 64'd0);
        checkOutput("drain_no_start", 64'(startCount - startsBefore), 64'd0);
        applyStimulus("after_drain", 3'b000, 64'd123, 64'd0);

        // Flush landing on the ready cycle discards the result and returns straight to IDLE.
        divLat     = 3;
        validsSeen = 0;
        stepCycle(1'b1, 3'b000, 64'd77, 64'd5, 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            stepCycle(1'b1, 3'b000, 64'd77, 64'd5, 1'b0, 1'b0);
            if (result_valid_o) validsSeen++;
        end
        stepCycle(1'b1, 3'b000, 64'd77, 64'd5, 1'b1, 1'b0);
        checkOutput("flush_ready_coincide", {63'd0, readyDriven}, 64'd1);
        if (result_valid_o) validsSeen++;
        checkOutput("flush_ready_no_valid", 64'(validsSeen), 64'd0);
        applyStimulus("after_flush_ready", 3'b010, 64'd9, 64'd0);
        applyStimulus("refetch_77_5", 3'b000, 64'd77, 64'd5);

        // Flush during DONE suppresses the valid pulse.
        stepCycle(1'b1, 3'b000, 64'd5, 64'd0, 1'b0, 1'b0);
        stepCycle(1'b1, 3'b000, 64'd5, 64'd0, 1'b1, 1'b0);
        checkOutput("done_flush_valid", {63'd0, result_valid_o}, 64'd0);
        stepCycle(1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 1'b0);
        checkOutput("done_flush_idle_valid", {63'd0, result_valid_o}, 64'd0);

        // Reset while RUN abandons the divide without draining.
        divLat = 10;
        stepCycle(1'b1, 3'b000, 64'd999, 64'd4, 1'b0, 1'b0);
        stepCycle(1'b1, 3'b000, 64'd999, 64'd4, 1'b0, 1'b0);
        stepCycle(1'b1, 3'b000, 64'd999, 64'd4, 1'b0, 1'b1);
        checkOutput("run_reset_stall", {63'd0, stall_o}, 64'd0);
        checkOutput("run_reset_valid", {63'd0, result_valid_o}, 64'd0);
        checkOutput("run_reset_start", {63'd0, div_start_o}, 64'd0);
        cacheValid = 0;
        stepCycle(1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 1'b0);
        checkOutput("post_reset_stall", {63'd0, stall_o}, 64'd0);
        checkOutput("post_reset_valid", {63'd0, result_valid_o}, 64'd0);
        applyStimulus("post_reset_div", 3'b000, 64'd999, 64'd4);

        lastA = 64'd999;
        lastB = 64'd4;
        for (int i = 0; i < 150; i++) begin
            rop  = 3'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            case (kind)
                0: rb = rop[0] ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    ra = rop[0] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    rb = rop[0] ? {$urandom, 32'hFFFF_FFFF} : {64{1'b1}};
                end
                2: begin
                    ra = lastA;
                    rb = lastB;
                end
                3: begin
                    ra = 64'($signed(32'($urandom_range(0, 2000)) - 32'sd1000));
                    rb = 64'($signed(32'($urandom_range(1, 40)) - 32'sd20));
                end
                default: ;
            endcase
            applyStimulus("random", rop, ra, rb);
            lastA = ra;
            lastB = rb;
        end

        stepCycle(1'b0, 3'b000, 64'd0, 64'd0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
